// File: rtl/irq_ctrl.sv
// Prioritized interrupt controller: edge/level capture, enable mask and a
// registered lowest-index-wins vector that the CPU claims through the bus.
module irq_ctrl #(
  parameter int NIRQ = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stb,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [31:0]     data_in,
  output logic [31:0]     data_out,
  output logic            ack,
  input  logic [NIRQ-1:0] irq_in,
  output logic            irq_out
);

  logic [NIRQ-1:0] r_srcQ;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] r_enable;
  logic [NIRQ-1:0] r_mode;
  logic            r_vecValid;
  logic [4:0]      r_vecNum;
  logic            r_irqOut;

  logic            w_pendWr;
  logic            w_maskWr;
  logic            w_modeWr;
  logic            w_claim;
  logic [NIRQ-1:0] w_claimMask;
  logic [NIRQ-1:0] w_clr;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_edgeNext;
  logic [NIRQ-1:0] w_pendNext;
  logic [NIRQ-1:0] w_active;
  logic [4:0]      w_lowest;
  logic            w_unused;

  assign w_pendWr = stb & we & (addr == 2'b00);
  assign w_maskWr = stb & we & (addr == 2'b01);
  assign w_modeWr = stb & we & (addr == 2'b10);
  assign w_claim  = stb & ~we & (addr == 2'b11) & r_vecValid;
  assign w_unused = ^data_in;

  always_comb begin
    w_claimMask = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (w_claim && (r_vecNum == 5'(i))) w_claimMask[i] = 1'b1;
    end
  end

  // A new edge overrides any clear in the same cycle; level sources simply track the input.
  assign w_rise     = irq_in & ~r_srcQ;
  assign w_clr      = w_claimMask | (w_pendWr ? data_in[NIRQ-1:0] : '0);
  assign w_edgeNext = w_rise | (r_pending & ~w_clr);
  assign w_pendNext = (r_mode & w_edgeNext) | (~r_mode & irq_in);

  assign w_active = r_pending & r_enable;

  always_comb begin
    w_lowest = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_lowest = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_srcQ     <= '0;
      r_pending  <= '0;
      r_enable   <= '0;
      r_mode     <= '0;
      r_vecValid <= 1'b0;
      r_vecNum   <= '0;
      r_irqOut   <= 1'b0;
    end else begin
      r_srcQ     <= irq_in;
      r_pending  <= w_pendNext;
      if (w_maskWr) r_enable <= data_in[NIRQ-1:0];
      if (w_modeWr) r_mode <= data_in[NIRQ-1:0];
      r_vecValid <= |w_active;
      r_vecNum   <= w_lowest;
      r_irqOut   <= |w_active;
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'b00:   data_out[NIRQ-1:0] = r_pending;
      2'b01:   data_out[NIRQ-1:0] = r_enable;
      2'b10:   data_out[NIRQ-1:0] = r_mode;
      default: data_out = {r_vecValid, 26'b0, r_vecNum};
    endcase
  end

  assign ack     = stb;
  assign irq_out = r_irqOut;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run
// compared against a per-source behavioural model.
module tb_irq_ctrl;

  localparam int NIRQ = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [1:0]      addr = '0;
  logic [31:0]     dataIn = '0;
  logic [31:0]     dataOut;
  logic            ack;
  logic [NIRQ-1:0] irqIn = '0;
  logic            irqOut;

  int checks = 0;
  int errors = 0;

  logic [NIRQ-1:0] mSrcq, mPend, mEn, mMode;
  logic            mVv;
  int              mVnum;

  irq_ctrl #(.NIRQ(NIRQ)) dut (
    .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr),
    .data_in(dataIn), .data_out(dataOut), .ack(ack),
    .irq_in(irqIn), .irq_out(irqOut)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic step();
    logic [NIRQ-1:0] np, act;
    logic            claim, nvv;
    int              nvn;
    claim = stb && !we && addr == 2'd3 && mVv;
    for (int i = 0; i < NIRQ; i++) begin
      if (!mMode[i]) np[i] = irqIn[i];
      else if (irqIn[i] && !mSrcq[i]) np[i] = 1'b1;
      else if ((stb && we && addr == 2'd0 && dataIn[i]) || (claim && mVnum == i)) np[i] = 1'b0;
      else np[i] = mPend[i];
    end
    act = mPend & mEn;
    nvv = (act != 0);
    nvn = 0;
    for (int i = 0; i < NIRQ; i++) begin
      if (act[i]) begin nvn = i; break; end
    end
    @(posedge clk); #1;
    if (stb && we && addr == 2'd1) mEn = dataIn[NIRQ-1:0];
    if (stb && we && addr == 2'd2) mMode = dataIn[NIRQ-1:0];
    mSrcq = irqIn;
    mPend = np;
    mVv   = nvv;
    mVnum = nvn;
  endtask

  task automatic doReset();
    rst = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; dataIn = '0; irqIn = '0;
    #3;
    mSrcq = '0; mPend = '0; mEn = '0; mMode = '0; mVv = 1'b0; mVnum = 0;
    rst = 1'b1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; dataIn = d;
    step();
    stb = 1'b0; we = 1'b0; dataIn = '0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = dataOut;
    step();
    stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    doReset();
    for (int a = 0; a < 4; a++) begin
      stb = 1'b1; addr = 2'(a);
      #1;
      checks++;
      if (dataOut !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, dataOut, 32'h0);
      end
    end
    checks++;
    if (ack !== 1'b1) begin errors++; $display("[TB] FAIL ack_follows_stb: got %b expected 1", ack); end
    stb = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || irqOut !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ack_irq: got ack=%b irq=%b expected 0 0", ack, irqOut);
    end
    busRead(2'd0, d);
  endtask

  task automatic test_level();
    logic [31:0] d;
    doReset();
    busWrite(2'd1, 32'h0001);
    irqIn[0] = 1'b1;
    step();
    checks++;
    if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL level_early: got %b expected 0", irqOut); end
    step();
    checks++;
    if (irqOut !== 1'b1) begin errors++; $display("[TB] FAIL level_rise: got %b expected 1", irqOut); end
    busRead(2'd3, d);
    checks++;
    if (d !== 32'h8000_0000) begin errors++; $display("[TB] FAIL level_vec: got %h expected 80000000", d); end
    irqIn[0] = 1'b0;
    step();
    checks++;
    if (irqOut !== 1'b1) begin errors++; $display("[TB] FAIL level_hold: got %b expected 1", irqOut); end
    step();
    checks++;
    if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL level_fall: got %b expected 0", irqOut); end
  endtask

  task automatic test_edge_claim();
    logic [31:0] d;
    doReset();
    busWrite(2'd2, 32'h0004);
    busWrite(2'd1, 32'h0004);
    irqIn[2] = 1'b1;
    step();
    irqIn[2] = 1'b0;
    step();
    busRead(2'd0, d);
    checks++;
    if (d !== 32'h0004) begin errors++; $display("[TB] FAIL edge_pend: got %h expected 00000004", d); end
    busRead(2'd3, d);
    checks++;
    if (d !== 32'h8000_0002) begin errors++; $display("[TB] FAIL edge_vec: got %h expected 80000002", d); end
    checks++;
    if (irqOut !== 1'b1) begin errors++; $display("[TB] FAIL edge_irq_held: got %b expected 1", irqOut); end
    step();
    checks++;
    if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL edge_irq_clear: got %b expected 0", irqOut); end
    busRead(2'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL edge_pend_clear: got %h expected 00000000", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    doReset();
    busWrite(2'd2, 32'h0030);
    busWrite(2'd1, 32'h0030);
    irqIn = 16'h0030;
    step();
    irqIn = '0;
    step();
    busRead(2'd3, d);
    checks++;
    if (d !== 32'h8000_0004) begin errors++; $display("[TB] FAIL prio_first: got %h expected 80000004", d); end
    step();
    busRead(2'd3, d);
    checks++;
    if (d !== 32'h8000_0005) begin errors++; $display("[TB] FAIL prio_second: got %h expected 80000005", d); end
    step();
    busRead(2'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL prio_empty: got %h expected 00000000", d); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    doReset();
    busWrite(2'd2, 32'h0002);
    irqIn[1] = 1'b1;
    busWrite(2'd0, 32'h0002);
    irqIn[1] = 1'b0;
    busRead(2'd0, d);
    checks++;
    if (d !== 32'h0002) begin errors++; $display("[TB] FAIL set_wins: got %h expected 00000002", d); end
    irqIn[3] = 1'b1;
    step();
    busWrite(2'd0, 32'h0008);
    busRead(2'd0, d);
    checks++;
    if (d !== 32'h000A) begin errors++; $display("[TB] FAIL level_w1c_ignored: got %h expected 0000000a", d); end
  endtask

  task automatic test_mask_and_reset();
    logic [31:0] d;
    doReset();
    irqIn[7] = 1'b1;
    step();
    step();
    busRead(2'd0, d);
    checks++;
    if (d !== 32'h0080 || irqOut !== 1'b0) begin
      errors++; $display("[TB] FAIL masked_pend: got pend=%h irq=%b expected 00000080 0", d, irqOut);
    end
    busWrite(2'd1, 32'h0080);
    checks++;
    if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL unmask_early: got %b expected 0", irqOut); end
    step();
    checks++;
    if (irqOut !== 1'b1) begin errors++; $display("[TB] FAIL unmask_irq: got %b expected 1", irqOut); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (irqOut !== 1'b0) begin errors++; $display("[TB] FAIL async_rst_irq: got %b expected 0", irqOut); end
    addr = 2'd0;
    #1;
    checks++;
    if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_pend: got %h expected 00000000", dataOut); end
    addr = 2'd1;
    #1;
    checks++;
    if (dataOut !== 32'h0) begin errors++; $display("[TB] FAIL async_rst_mask: got %h expected 00000000", dataOut); end
    doReset();
  endtask

  // Random bus traffic and sparse interrupt activity against the model.
  task automatic test_random();
    logic [31:0] exp;
    doReset();
    for (int n = 0; n < 400; n++) begin
      irqIn  = 16'($urandom & $urandom & $urandom);
      stb    = ($urandom_range(0, 2) == 0);
      we     = $urandom_range(0, 1) == 1;
      addr   = 2'($urandom_range(0, 3));
      dataIn = $urandom;
      #1;
      case (addr)
        2'd0:    exp = {16'h0, mPend};
        2'd1:    exp = {16'h0, mEn};
        2'd2:    exp = {16'h0, mMode};
        default: exp = mVv ? {1'b1, 26'b0, 5'(mVnum)} : 32'h0;
      endcase
      checks++;
      if (dataOut !== exp) begin
        errors++; $display("[TB] FAIL rand_read%0d: got %h expected %h", n, dataOut, exp);
      end
      checks++;
      if (irqOut !== mVv) begin
        errors++; $display("[TB] FAIL rand_irq%0d: got %b expected %b", n, irqOut, mVv);
      end
      step();
    end
    stb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_claim();
    test_priority();
    test_set_wins();
    test_mask_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
